turn_signal_conditioner: RTL

Input-side front end for the Mustang tail-light sequencer. Synchronizes the three raw dashboard switches (left, right, hazard) into the Clock domain, debounces each one, and generates the slow Step clock-enable that advances the sequencer's light pattern. It also emits a Restart pulse whenever the debounced request changes, so the sequencer re-enters its OFF state with a full step interval ahead of it.

---
 rtl/turn_signal_conditioner.sv | 120 ++++++++++++
 1 files changed

// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner
// Front end for the tail-light sequencer: brings the three raw dashboard
// switches into the Clock domain, debounces each one independently, and
// produces the Step clock-enable plus a Restart pulse on any request change.
module turn_signal_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP_DIV        = 4000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic LeftRaw,
    input  logic RightRaw,
    input  logic HazardRaw,
    output logic Left,
    output logic Right,
    output logic Hazard,
    output logic Step,
    output logic Restart
);

    localparam int NUM_CH = 3;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_DIV);

    // Count value on which the next differing edge would reach DEBOUNCE_CYCLES.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    // Channel order: bit 0 = left, bit 1 = right, bit 2 = hazard.
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync2_reg;
    logic [NUM_CH-1:0] clean_reg;
    logic [NUM_CH-1:0] clean_next;
    logic              change;

    logic [STEP_W-1:0] step_count_reg;
    logic              step_reg;
    logic              restart_reg;

    assign raw = {HazardRaw, RightRaw, LeftRaw};

    // Two-flop synchronizer; only sync2 is used downstream.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // One independent debouncer per channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_debounce
        logic [DB_W-1:0] count_reg;
        logic [DB_W-1:0] count_next;
        logic            ch_clean_next;

        // Any edge that agrees with the clean output restarts the hold window.
        always_comb begin
            count_next    = count_reg;
            ch_clean_next = clean_reg[gi];
            if (sync2_reg[gi] == clean_reg[gi]) begin
                count_next = '0;
            end else if (count_reg == DB_LAST) begin
                count_next    = '0;
                ch_clean_next = sync2_reg[gi];
            end else begin
                count_next = count_reg + 1'b1;
            end
        end

        // Debounce counter and clean output state.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                count_reg     <= '0;
                clean_reg[gi] <= 1'b0;
            end else begin
                count_reg     <= count_next;
                clean_reg[gi] <= ch_clean_next;
            end
        end

        assign clean_next[gi] = ch_clean_next;
    end

    // A request change is detected on the same edge the clean outputs update,
    // so Restart lines up with the new request and the divider realigns there.
    assign change = |(clean_next ^ clean_reg);

    // Step divider with Restart taking priority over the wrap.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_count_reg <= '0;
            step_reg       <= 1'b0;
            restart_reg    <= 1'b0;
        end else if (change) begin
            step_count_reg <= '0;
            step_reg       <= 1'b0;
            restart_reg    <= 1'b1;
        end else if (step_count_reg == STEP_LAST) begin
            step_count_reg <= '0;
            step_reg       <= 1'b1;
            restart_reg    <= 1'b0;
        end else begin
            step_count_reg <= step_count_reg + 1'b1;
            step_reg       <= 1'b0;
            restart_reg    <= 1'b0;
        end
    end

    // Conflicting requests are passed through untouched.
    assign Left    = clean_reg[0];
    assign Right   = clean_reg[1];
    assign Hazard  = clean_reg[2];
    assign Step    = step_reg;
    assign Restart = restart_reg;

endmodule
